// File: rtl/sub_4bit.sv
// sub_4bit: registered 4-bit add / subtract / magnitude-compare slice with carry and overflow flags.
// Latency: 1 cycle. Operands and mode are sampled on the rising edge of clk, and the result is visible after that edge.
// Backpressure: none. A new operation is accepted every cycle, and rst_n low clears all outputs at once.
//
// Ports:
//    clk    rising-edge clock
//    rst_n  asynchronous active-low reset
//    A, B   4-bit operands (unsigned or two's complement)
//    M      0 = add, 1 = subtract (ignored while C = 1)
//    C      1 = compare A against B (overrides M)
//    OUT    registered result, or compare flags {slt, ult, eq, ugt}
//    cout   registered carry-out; after a subtract or compare this means A >= B unsigned
//    ov     registered signed overflow (always 0 in compare mode)

module sub_4bit (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic       M,
   input  logic       C,
   output logic [3:0] OUT,
   output logic       cout,
   output logic       ov
);

   // Shared ripple-carry datapath. Compare also runs A - B through it.
   logic       sub;
   logic [3:0] b_eff;
   logic [3:0] s;
   logic       c4;

   always_comb begin
      logic [4:0] carry;
      sub      = M | C;
      b_eff    = B ^ {4{sub}};
      carry    = '0;
      s        = '0;
      carry[0] = sub;
      for (int i = 0; i < 4; i++) begin
         s[i]       = A[i] ^ b_eff[i] ^ carry[i];
         carry[i+1] = (A[i] & b_eff[i]) | (carry[i] & (A[i] ^ b_eff[i]));
      end
      c4 = carry[4];
   end

   // Signed overflow terms for the add and subtract interpretations.
   logic ov_add;
   logic ov_sub;

   assign ov_add = (A[3] == B[3]) & (s[3] != A[3]);
   assign ov_sub = (A[3] != B[3]) & (s[3] != A[3]);

   // Compare flags, all derived from the A - B pass.
   // A zero difference mod 16 means equal, and a set c4 means no borrow (A >= B).
   logic eq;
   logic ugt;
   logic ult;
   logic slt;

   assign eq  = (s == 4'b0000);
   assign ult = ~c4;
   assign ugt = c4 & ~eq;
   assign slt = s[3] ^ ov_sub;

   // Next-state selection.
   logic [3:0] out_d;
   logic [3:0] out_q;
   logic       cout_d;
   logic       cout_q;
   logic       ov_d;
   logic       ov_q;

   always_comb begin
      out_d  = s;
      cout_d = c4;
      ov_d   = 1'b0;
      if (C) begin
         out_d = {slt, ult, eq, ugt};
      end else if (M) begin
         ov_d = ov_sub;
      end else begin
         ov_d = ov_add;
      end
   end

   // Output registers. This is the only state in the block.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q  <= 4'b0000;
         cout_q <= 1'b0;
         ov_q   <= 1'b0;
      end else begin
         out_q  <= out_d;
         cout_q <= cout_d;
         ov_q   <= ov_d;
      end
   end

   assign OUT  = out_q;
   assign cout = cout_q;
   assign ov   = ov_q;

endmodule

// File: tb/tb_sub_4bit.sv
// tb_sub_4bit: self-checking bench for sub_4bit against an arithmetic reference model.
// Latency: inputs are driven on the falling edge, and outputs are sampled 1 time unit after the next rising edge.
// Backpressure: none. Every randomized cycle carries a new operation.

module tb_sub_4bit;

   logic       clk;
   logic       rst_n;
   logic [3:0] A;
   logic [3:0] B;
   logic       M;
   logic       C;
   logic [3:0] OUT;
   logic       cout;
   logic       ov;

   int checks;
   int errors;
   logic [5:0] last_exp;   // {OUT, cout, ov} expected to be held in the registers

   sub_4bit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .A     (A),
      .B     (B),
      .M     (M),
      .C     (C),
      .OUT   (OUT),
      .cout  (cout),
      .ov    (ov)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model built from plain integer arithmetic. It returns {OUT, cout, ov}.
   function automatic logic [5:0] model(input int a, input int b, input bit m, input bit c);
      int sa;
      int sb;
      int r;
      logic [3:0] o;
      logic co;
      logic v;
      sa = (a >= 8) ? a - 16 : a;
      sb = (b >= 8) ? b - 16 : b;
      if (c) begin
         o  = {logic'(sa < sb), logic'(a < b), logic'(a == b), logic'(a > b)};
         co = (a >= b);
         v  = 1'b0;
      end else if (m) begin
         r  = sa - sb;
         o  = 4'((a - b + 16) % 16);
         co = (a >= b);
         v  = (r > 7) || (r < -8);
      end else begin
         r  = sa + sb;
         o  = 4'((a + b) % 16);
         co = (a + b) > 15;
         v  = (r > 7) || (r < -8);
      end
      return {o, co, v};
   endfunction

   // Drive one operation, then wait until just after the capturing edge.
   task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic m, input logic c);
      @(negedge clk);
      A = a; B = b; M = m; C = c;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      A = 4'd5; B = 4'd2; M = 1'b0; C = 1'b0;
      #2;
      checks++;
      if ({OUT, cout, ov} !== 6'b0) begin
         errors++;
         $display("FAIL reset_async got=%b want=%b", {OUT, cout, ov}, 6'b0);
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({OUT, cout, ov} !== 6'b0) begin
         errors++;
         $display("FAIL reset_held got=%b want=%b", {OUT, cout, ov}, 6'b0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if ({OUT, cout, ov} !== 6'b0) begin
         errors++;
         $display("FAIL reset_release_hold got=%b want=%b", {OUT, cout, ov}, 6'b0);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({OUT, cout, ov} !== 6'b0111_0_0) begin
         errors++;
         $display("FAIL reset_first_add got=%b want=%b", {OUT, cout, ov}, 6'b0111_0_0);
      end
      last_exp = 6'b0111_0_0;
   endtask

   task automatic test_subtract();
      apply(4'd5, 4'd2, 1'b1, 1'b0);
      checks++;
      if ({OUT, cout, ov} !== 6'b0011_1_0) begin
         errors++;
         $display("FAIL sub_5_2 got=%b want=%b", {OUT, cout, ov}, 6'b0011_1_0);
      end
      apply(4'd2, 4'd5, 1'b1, 1'b0);
      checks++;
      if ({OUT, cout, ov} !== 6'b1101_0_0) begin
         errors++;
         $display("FAIL sub_2_5 got=%b want=%b", {OUT, cout, ov}, 6'b1101_0_0);
      end
      last_exp = 6'b1101_0_0;
   endtask

   task automatic test_compare();
      logic [5:0] exp;
      apply(4'd5, 4'd2, 1'b1, 1'b1);
      checks++;
      if ({OUT, cout, ov} !== 6'b0001_1_0) begin
         errors++;
         $display("FAIL cmp_5_2 got=%b want=%b", {OUT, cout, ov}, 6'b0001_1_0);
      end
      apply(4'd9, 4'd9, 1'b0, 1'b1);
      checks++;
      if ({OUT, cout, ov} !== 6'b0010_1_0) begin
         errors++;
         $display("FAIL cmp_9_9 got=%b want=%b", {OUT, cout, ov}, 6'b0010_1_0);
      end
      apply(4'd8, 4'd1, 1'b1, 1'b1);
      checks++;
      if ({OUT, cout, ov} !== 6'b1001_1_0) begin
         errors++;
         $display("FAIL cmp_8_1 got=%b want=%b", {OUT, cout, ov}, 6'b1001_1_0);
      end
      // Exhaustive sweep. M toggles to show that it is ignored in compare mode.
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            apply(4'(a), 4'(b), 1'(a ^ b), 1'b1);
            exp = model(a, b, 1'b0, 1'b1);
            checks++;
            if ({OUT, cout, ov} !== exp || $countones(OUT[2:0]) != 1) begin
               errors++;
               $display("FAIL cmp_sweep a=%0d b=%0d got=%b want=%b", a, b, {OUT, cout, ov}, exp);
            end
            last_exp = exp;
         end
      end
   endtask

   task automatic test_overflow();
      apply(4'd7, 4'd1, 1'b0, 1'b0);
      checks++;
      if ({OUT, cout, ov} !== 6'b1000_0_1) begin
         errors++;
         $display("FAIL add_7_1 got=%b want=%b", {OUT, cout, ov}, 6'b1000_0_1);
      end
      apply(4'd15, 4'd1, 1'b0, 1'b0);
      checks++;
      if ({OUT, cout, ov} !== 6'b0000_1_0) begin
         errors++;
         $display("FAIL add_15_1 got=%b want=%b", {OUT, cout, ov}, 6'b0000_1_0);
      end
      apply(4'd8, 4'd1, 1'b1, 1'b0);
      checks++;
      if ({OUT, cout, ov} !== 6'b0111_1_1) begin
         errors++;
         $display("FAIL sub_8_1 got=%b want=%b", {OUT, cout, ov}, 6'b0111_1_1);
      end
      last_exp = 6'b0111_1_1;
   endtask

   task automatic test_back_to_back();
      logic [3:0] a;
      logic [3:0] b;
      logic m;
      logic c;
      logic [5:0] exp;
      for (int i = 0; i < 300; i++) begin
         a = 4'($urandom_range(0, 15));
         b = 4'($urandom_range(0, 15));
         m = 1'($urandom_range(0, 1));
         c = ($urandom_range(0, 3) == 0);
         @(negedge clk);
         A = a; B = b; M = m; C = c;
         #1;
         // A new input must not reach the outputs before the capturing edge.
         checks++;
         if ({OUT, cout, ov} !== last_exp) begin
            errors++;
            $display("FAIL b2b_hold i=%0d got=%b want=%b", i, {OUT, cout, ov}, last_exp);
         end
         @(posedge clk);
         #1;
         exp = model(int'(a), int'(b), m, c);
         checks++;
         if ({OUT, cout, ov} !== exp) begin
            errors++;
            $display("FAIL b2b_result i=%0d a=%0d b=%0d m=%b c=%b got=%b want=%b",
                     i, a, b, m, c, {OUT, cout, ov}, exp);
         end
         last_exp = exp;
      end
   endtask

   task automatic test_mid_reset();
      logic [5:0] exp;
      apply(4'd6, 4'd3, 1'b0, 1'b0);
      checks++;
      if ({OUT, cout, ov} !== model(6, 3, 1'b0, 1'b0)) begin
         errors++;
         $display("FAIL midrst_pre got=%b want=%b", {OUT, cout, ov}, model(6, 3, 1'b0, 1'b0));
      end
      @(negedge clk);
      A = 4'd3; B = 4'd12; M = 1'b1; C = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({OUT, cout, ov} !== 6'b0) begin
         errors++;
         $display("FAIL midrst_async got=%b want=%b", {OUT, cout, ov}, 6'b0);
      end
      #1 rst_n = 1'b1;
      #1;
      checks++;
      if ({OUT, cout, ov} !== 6'b0) begin
         errors++;
         $display("FAIL midrst_release_hold got=%b want=%b", {OUT, cout, ov}, 6'b0);
      end
      @(posedge clk);
      #1;
      exp = model(3, 12, 1'b1, 1'b0);
      checks++;
      if ({OUT, cout, ov} !== exp) begin
         errors++;
         $display("FAIL midrst_resume got=%b want=%b", {OUT, cout, ov}, exp);
      end
      last_exp = exp;
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      last_exp = '0;
      rst_n    = 1'b0;
      A = '0; B = '0; M = 1'b0; C = 1'b0;
      test_reset();
      test_subtract();
      test_compare();
      test_overflow();
      test_back_to_back();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
